bcd_page_sequencer: RTL and testbench
=====================================

Name: bcd_page_sequencer

Overview:
- Controller that sequences the binary-to-BCD converter and the paged 7-segment display of the 36-bit event counter.
- Each frame it:
  - requests one conversion;
  - snapshots the 9 BCD digits coherently;
  - steps through four display pages (blank/dash, high, mid, low digit groups) on HEX2..HEX0, with a page marker on HEX3.
- Replaces the free-running slow-clock page rotation with a single-clock, dwell-counted scheduler.

Parameters:
- DWELL_CYCLES, 25_000_000: clk cycles each page is shown (minimum 2).
- TIMEOUT_CYCLES, 1024: maximum clk cycles to wait for conv_done after conv_start.
- LZ_BLANK, 1: 1 = blank leading zero digits of the snapshot (never digit 0).

Ports:
- clk, input, 1: system clock (CLOCK_50 domain).
- rst, input, 1: asynchronous, active-high reset.
- hold, input, 1: 1 = freeze page rotation on the current page.
- conv_start, output, 1: one-cycle pulse requesting a BCD conversion.
- conv_done, input, 1: one-cycle pulse; bcd_in is valid in this cycle.
- bcd_in, input, 36: nine BCD digits; [3:0] = digit 0 (least significant), [35:32] = digit 8.
- digits, output, 12: HEX2/HEX1/HEX0 BCD codes, [11:8] leftmost; 4'hF = blank.
- hex3_seg, output, 7: active-low segment pattern for the HEX3 page marker.
- page, output, 2: current page (0 = A, 1 = B, 2 = C, 3 = D).
- frame_start, output, 1: one-cycle pulse on entry to page A.
- conv_err, output, 1: sticky; set on conversion timeout.

Behaviour:
- Reset (async, immediate):
  - page = A, digits = 12'hFFF, hex3_seg = 7'b0111111;
  - conv_start = 0, frame_start = 0, conv_err = 0;
  - snapshot = 36'hFFFFFFFFF (all blank);
  - dwell and timeout counters = 0.
- First rising clk after rst deasserts: frame_start = 1 and conv_start = 1 (one cycle each); state becomes A_WAIT.
- States:
  - A_WAIT: page A; conversion outstanding.
  - A_DWELL: page A; conversion resolved.
  - B, C, D.
- A_WAIT:
  - The dwell counter runs (unless hold) and the timeout counter runs unconditionally.
  - On conv_done: latch bcd_in into snapshot in the same edge; go to A_DWELL with the dwell count preserved.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without conv_done: set conv_err, keep the old snapshot, go to A_DWELL.
- A_DWELL: when the dwell count reaches DWELL_CYCLES-1 and hold = 0, go to B.
- Exit rule for page A:
  - Page A lasts max(DWELL_CYCLES, cycles to done/timeout).
  - It never exits while a conversion is outstanding.
- B, C, D:
  - Each lasts exactly DWELL_CYCLES cycles when hold = 0.
  - Transitions are B -> C -> D -> A_WAIT.
  - Entering A_WAIT issues frame_start and conv_start pulses on the entry cycle.
- Dwell counter: clears on every page change.
- hold = 1:
  - The dwell counter stops; the current page persists indefinitely.
  - In A_WAIT, the timeout counter still runs and conv_done is still accepted.
- Page outputs (registered; update on the cycle the page changes):
  - A: digits = FFF, hex3_seg = 7'b0111111.
  - B: digits = snapshot digits 8,7,6; hex3_seg = 7'b0001000.
  - C: digits = snapshot digits 5,4,3; hex3_seg = 7'b0000000.
  - D: digits = snapshot digits 2,1,0; hex3_seg = 7'b1000110.
- LZ_BLANK = 1:
  - Applied when the snapshot is latched.
  - Digits above the most significant nonzero digit are replaced by 4'hF.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
- conv_done handling:
  - Outside A_WAIT, conv_done is ignored; the snapshot is unchanged.
  - conv_done in the same cycle as the timeout: conv_done wins and conv_err is not set.
- conv_err clears only on rst.
- rst asserted mid-frame: everything returns to reset values immediately; no partial page output.

Decomposition:
- Shared package:
  - page encodings PAGE_A..PAGE_D;
  - the four HEX3 marker constants;
  - BLANK_DIGIT = 4'hF;
  - state enum for the FSM.
- One sub-module, lz_blanker: combinational 36-bit leading-zero blanker used at snapshot latch.
- Dwell and timeout counters stay inline.

Test Plan (DWELL_CYCLES = 4, TIMEOUT_CYCLES = 8):
- Reset release; conv_done 2 cycles after conv_start, bcd_in = 36'h000012345 -> page A for 4 cycles, then:
  - B digits FFF;
  - C digits F12 (leading zeros blanked);
  - D digits 345;
  - 4 cycles each, then a second frame_start/conv_start.
- conv_done arrives 6 cycles after conv_start -> page A lasts 7 cycles, then B; conv_err stays 0.
- conv_done never arrives -> conv_err = 1 after 8 cycles; previous snapshot shown on pages B–D; next frame retries conv_start.
- hold = 1 for 20 cycles during page C -> page/digits constant, no conv_start; after hold drops, C completes its remaining dwell, then D.
- conv_done pulsed during page C with bcd_in = 36'h999999999 -> ignored; D shows the old snapshot.
- rst pulsed mid-page D -> digits = FFF and hex3_seg = 7'b0111111 asynchronously, conv_err = 0; after release, conv_start on the first clk edge.
- LZ_BLANK = 1, bcd_in = 0 -> D shows FF0.

Source files
------------

// File: rtl/bcd_page_sequencer_pkg.sv
// Shared types and constants for the BCD page sequencer.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package bcd_page_sequencer_pkg;

    // Value shown on a digit position that should stay dark.
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // Active-low HEX3 marker patterns, one per display page.
    localparam logic [6:0] HEX3_PAGE_A = 7'b0111111;  // dash
    localparam logic [6:0] HEX3_PAGE_B = 7'b0001000;
    localparam logic [6:0] HEX3_PAGE_C = 7'b0000000;
    localparam logic [6:0] HEX3_PAGE_D = 7'b1000110;

    typedef enum logic [1:0] {
        PAGE_A = 2'd0,
        PAGE_B = 2'd1,
        PAGE_C = 2'd2,
        PAGE_D = 2'd3
    } page_t;

    // ST_INIT exists only between reset release and the first clock edge,
    // so that edge can issue the opening frame_start/conv_start pair.
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_A_WAIT  = 3'd1,
        ST_A_DWELL = 3'd2,
        ST_B       = 3'd3,
        ST_C       = 3'd4,
        ST_D       = 3'd5
    } seq_state_t;

    function automatic logic [6:0] page_marker(input page_t p);
        logic [6:0] m;
        case (p)
            PAGE_A:  m = HEX3_PAGE_A;
            PAGE_B:  m = HEX3_PAGE_B;
            PAGE_C:  m = HEX3_PAGE_C;
            default: m = HEX3_PAGE_D;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd_page_sequencer_if.sv
// Conversion handshake between the page sequencer and the binary-to-BCD converter.
// Latency: conv_done may follow conv_start by any number of cycles; bcd_in valid only with conv_done.
// Backpressure: none; the sequencer bounds the wait with its own timeout.
// Signals: conv_start (request pulse), conv_done (result pulse), bcd_in[35:0] (nine digits, [3:0] = LSD).
interface bcd_page_sequencer_if;
    logic        conv_start;
    logic        conv_done;
    logic [35:0] bcd_in;

    modport master (output conv_start, input conv_done, input bcd_in);
    modport slave  (input conv_start, output conv_done, output bcd_in);
endinterface

// File: rtl/bcd_page_sequencer_lz_blanker.sv
// Replaces leading zero digits of a 9-digit BCD value with the blank code; digit 0 is never blanked.
// Latency: combinational.
// Backpressure: none.
// Ports: raw[35:0] in, blanked[35:0] out.
module lz_blanker
    import bcd_page_sequencer_pkg::*;
(
    input  logic [35:0] raw,
    output logic [35:0] blanked
);

    logic leading;

    // Walk down from the top digit; blanking stops at the first nonzero digit.
    always_comb begin
        blanked = raw;
        leading = 1'b1;
        for (int i = 8; i >= 1; i--) begin
            if (leading && (raw[i*4 +: 4] == 4'd0)) begin
                blanked[i*4 +: 4] = BLANK_DIGIT;
            end else begin
                leading = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_page_sequencer.sv
// Frame scheduler: one BCD conversion per frame, coherent snapshot, four dwell-counted display pages.
// Latency: outputs registered; page outputs change on the edge that changes page.
// Backpressure: hold freezes rotation; page A never exits while a conversion is outstanding (bounded by timeout).
// Ports: clk, rst (async, active high), hold, conv (converter handshake, master side),
//        digits[11:0] (HEX2..HEX0, F = blank), hex3_seg[6:0], page[1:0], frame_start, conv_err (sticky).
module bcd_page_sequencer
    import bcd_page_sequencer_pkg::*;
#(
    parameter int DWELL_CYCLES   = 25_000_000,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LZ_BLANK       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    bcd_page_sequencer_if.master        conv,
    output logic [11:0]                 digits,
    output logic [6:0]                  hex3_seg,
    output logic [1:0]                  page,
    output logic                        frame_start,
    output logic                        conv_err
);

    localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t     state;
    logic [DW-1:0]  dwell_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic [35:0]    snapshot;
    logic [35:0]    blanked;
    logic [35:0]    snap_next;

    lz_blanker u_lz_blanker (
        .raw     (conv.bcd_in),
        .blanked (blanked)
    );

    assign snap_next = (LZ_BLANK != 0) ? blanked : conv.bcd_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_INIT;
            page            <= PAGE_A;
            digits          <= {3{BLANK_DIGIT}};
            hex3_seg        <= HEX3_PAGE_A;
            conv.conv_start <= 1'b0;
            frame_start     <= 1'b0;
            conv_err        <= 1'b0;
            snapshot        <= '1;
            dwell_cnt       <= '0;
            tmo_cnt         <= '0;
        end else begin
            conv.conv_start <= 1'b0;
            frame_start     <= 1'b0;

            case (state)
                ST_INIT: begin
                    state           <= ST_A_WAIT;
                    conv.conv_start <= 1'b1;
                    frame_start     <= 1'b1;
                    dwell_cnt       <= '0;
                    tmo_cnt         <= '0;
                end

                ST_A_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Saturate so the dwell credit earned while waiting survives into A_DWELL.
                    if (!hold && (dwell_cnt != DWELL_LAST)) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                    // A result arriving on the timeout cycle is still taken.
                    if (conv.conv_done) begin
                        snapshot <= snap_next;
                        state    <= ST_A_DWELL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        conv_err <= 1'b1;
                        state    <= ST_A_DWELL;
                    end
                end

                ST_A_DWELL, ST_B, ST_C, ST_D: begin
                    if (!hold) begin
                        if (dwell_cnt != DWELL_LAST) begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end else begin
                            dwell_cnt <= '0;
                            case (state)
                                ST_A_DWELL: begin
                                    state    <= ST_B;
                                    page     <= PAGE_B;
                                    digits   <= snapshot[35:24];
                                    hex3_seg <= page_marker(PAGE_B);
                                end
                                ST_B: begin
                                    state    <= ST_C;
                                    page     <= PAGE_C;
                                    digits   <= snapshot[23:12];
                                    hex3_seg <= page_marker(PAGE_C);
                                end
                                ST_C: begin
                                    state    <= ST_D;
                                    page     <= PAGE_D;
                                    digits   <= snapshot[11:0];
                                    hex3_seg <= page_marker(PAGE_D);
                                end
                                default: begin
                                    // Leaving D opens the next frame.
                                    state           <= ST_A_WAIT;
                                    page            <= PAGE_A;
                                    digits          <= {3{BLANK_DIGIT}};
                                    hex3_seg        <= page_marker(PAGE_A);
                                    tmo_cnt         <= '0;
                                    conv.conv_start <= 1'b1;
                                    frame_start     <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_page_sequencer.sv
// Self-checking bench for bcd_page_sequencer with DWELL_CYCLES = 4, TIMEOUT_CYCLES = 8.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_page_sequencer;

    localparam logic [6:0] M_A = 7'b0111111;
    localparam logic [6:0] M_B = 7'b0001000;
    localparam logic [6:0] M_C = 7'b0000000;
    localparam logic [6:0] M_D = 7'b1000110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [11:0] digits;
    logic [6:0]  hex3_seg;
    logic [1:0]  page;
    logic        frame_start;
    logic        conv_err;

    int checks = 0;
    int errors = 0;

    bcd_page_sequencer_if cif ();

    bcd_page_sequencer #(
        .DWELL_CYCLES   (4),
        .TIMEOUT_CYCLES (8),
        .LZ_BLANK       (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .conv        (cif),
        .digits      (digits),
        .hex3_seg    (hex3_seg),
        .page        (page),
        .frame_start (frame_start),
        .conv_err    (conv_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    typedef struct {
        logic        done;
        logic [35:0] bcd;
        logic [1:0]  pg;
        logic [11:0] dig;
        logic [6:0]  hex;
        logic        cs;
        logic        fs;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic done, input logic [35:0] bcd, input logic [1:0] pg,
                                input logic [11:0] dig, input logic [6:0] hex, input logic cs,
                                input logic fs);
        vec_t v;
        v.done = done; v.bcd = bcd; v.pg = pg; v.dig = dig; v.hex = hex; v.cs = cs; v.fs = fs;
        return v;
    endfunction

    // One whole frame, starting at its first (A_WAIT entry) cycle.
    // done_at / junk_at: cycle index of a real / ignored-garbage conv_done (-1 = none).
    // hl: hold cycles inserted from the second cycle of page C.
    // err_from: first cycle index where conv_err must read 1.
    task automatic run_frame(input string tag, input int done_at, input logic [35:0] val,
                             input int a_len, input int hl, input int junk_at,
                             input logic [11:0] eb, input logic [11:0] ec, input logic [11:0] ed,
                             input int err_from);
        logic [1:0]  pg;
        logic [11:0] dig;
        logic [6:0]  hx;
        for (int r = 0; r < a_len + 12 + hl; r++) begin
            @(negedge clk);
            if (r < a_len) begin
                pg = 2'd0; dig = 12'hFFF; hx = M_A;
            end else if (r < a_len + 4) begin
                pg = 2'd1; dig = eb; hx = M_B;
            end else if (r < a_len + 8 + hl) begin
                pg = 2'd2; dig = ec; hx = M_C;
            end else begin
                pg = 2'd3; dig = ed; hx = M_D;
            end
            check($sformatf("%s r%0d page", tag, r), 64'(page), 64'(pg));
            check($sformatf("%s r%0d digits", tag, r), 64'(digits), 64'(dig));
            check($sformatf("%s r%0d hex3", tag, r), 64'(hex3_seg), 64'(hx));
            check($sformatf("%s r%0d conv_start", tag, r), 64'(cif.conv_start), 64'(r == 0));
            check($sformatf("%s r%0d frame_start", tag, r), 64'(frame_start), 64'(r == 0));
            check($sformatf("%s r%0d conv_err", tag, r), 64'(conv_err), 64'(r >= err_from));
            cif.conv_done = (r == done_at) || (r == junk_at);
            cif.bcd_in    = (r == junk_at) ? 36'h999999999 : val;
            hold          = (r >= a_len + 5) && (r < a_len + 5 + hl);
        end
        cif.conv_done = 1'b0;
        hold          = 1'b0;
    endtask

    initial begin
        cif.conv_done = 1'b0;
        cif.bcd_in    = '0;

        // First frame: result two cycles after the request, 12345 with leading zeros blanked.
        vecs[0]  = mk(1'b0, 36'h000012345, 2'd0, 12'hFFF, M_A, 1'b1, 1'b1);
        vecs[1]  = mk(1'b0, 36'h000012345, 2'd0, 12'hFFF, M_A, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 36'h000012345, 2'd0, 12'hFFF, M_A, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 36'h000012345, 2'd0, 12'hFFF, M_A, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 36'h000012345, 2'd1, 12'hFFF, M_B, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 36'h000012345, 2'd1, 12'hFFF, M_B, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 36'h000012345, 2'd1, 12'hFFF, M_B, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 36'h000012345, 2'd1, 12'hFFF, M_B, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 36'h000012345, 2'd2, 12'hF12, M_C, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 36'h000012345, 2'd2, 12'hF12, M_C, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 36'h000012345, 2'd2, 12'hF12, M_C, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 36'h000012345, 2'd2, 12'hF12, M_C, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 36'h000012345, 2'd3, 12'h345, M_D, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 36'h000012345, 2'd3, 12'h345, M_D, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 36'h000012345, 2'd3, 12'h345, M_D, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 36'h000012345, 2'd3, 12'h345, M_D, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset page", 64'(page), 64'd0);
        check("reset digits", 64'(digits), 64'hFFF);
        check("reset hex3", 64'(hex3_seg), 64'(M_A));
        check("reset conv_start", 64'(cif.conv_start), 64'd0);
        check("reset frame_start", 64'(frame_start), 64'd0);
        check("reset conv_err", 64'(conv_err), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d page", i), 64'(page), 64'(vecs[i].pg));
            check($sformatf("vec%0d digits", i), 64'(digits), 64'(vecs[i].dig));
            check($sformatf("vec%0d hex3", i), 64'(hex3_seg), 64'(vecs[i].hex));
            check($sformatf("vec%0d conv_start", i), 64'(cif.conv_start), 64'(vecs[i].cs));
            check($sformatf("vec%0d frame_start", i), 64'(frame_start), 64'(vecs[i].fs));
            check($sformatf("vec%0d conv_err", i), 64'(conv_err), 64'd0);
            cif.conv_done = vecs[i].done;
            cif.bcd_in    = vecs[i].bcd;
        end
        cif.conv_done = 1'b0;

        // Late result on the sixth cycle of the request: page A stretches to 7 cycles, no error.
        run_frame("late", 5, 36'h000000987, 7, 0, -1, 12'hFFF, 12'hFFF, 12'h987, 1000);

        // No result: error after 8 cycles, previous snapshot kept.
        run_frame("tmo", -1, 36'h000054321, 9, 0, -1, 12'hFFF, 12'hFFF, 12'h987, 8);

        // Zero value, 20-cycle hold in C, then a stray result in C that must be ignored.
        run_frame("hold", 2, 36'h000000000, 4, 20, 30, 12'hFFF, 12'hFFF, 12'hFF0, 0);

        // Reset mid page D.
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            cif.conv_done = (r == 2);
            cif.bcd_in    = 36'h000000005;
        end
        cif.conv_done = 1'b0;
        check("preRst page", 64'(page), 64'd3);
        check("preRst digits", 64'(digits), 64'hFF5);
        check("preRst conv_err", 64'(conv_err), 64'd1);
        rst = 1'b1;
        #1;
        check("asyncRst page", 64'(page), 64'd0);
        check("asyncRst digits", 64'(digits), 64'hFFF);
        check("asyncRst hex3", 64'(hex3_seg), 64'(M_A));
        check("asyncRst conv_err", 64'(conv_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postRst conv_start", 64'(cif.conv_start), 64'd1);
        check("postRst frame_start", 64'(frame_start), 64'd1);
        check("postRst page", 64'(page), 64'd0);
        check("postRst digits", 64'(digits), 64'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
